// File: rtl/fp_divider_param.sv
// fp_divider_param: sequential IEEE-754-style divider (restoring), parametrised widths.
// Define FPDIV_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_divider_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic [4:0]   flags
);
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 3);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q, res, sp_res, rnd_res;
  logic [4:0] flg, sp_flg, rnd_flg;
  logic sign, sab, sp, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb, frac;
  logic signed [EW-1:0] e, e_u, e_r;
  logic [MAN_W:0] mb;
  logic [MAN_W+1:0] r, r_sub;
  logic [MAN_W+2:0] q;
  logic [CW-1:0] cnt;
  logic ge, g, st, up, of, uf;
  logic [MAN_W+1:0] sum;
  assign sab = a_q[W-1] ^ b_q[W-1];
  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];
  assign a_nan = (&ea) & (|fa);
  assign b_nan = (&eb) & (|fb);
  assign a_inf = (&ea) & ~(|fa);
  assign b_inf = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);
  assign e_u = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
  assign busy = state != IDLE;
  // Special-value resolution; default result is signed infinity
  always_comb begin
    sp = 1'b1;
    sp_res = {sab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    sp_flg = 5'b00000;
    if (a_nan | b_nan) sp_res = QNAN;
    else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_res = QNAN;
      sp_flg = 5'b10000;
    end
    else if (a_inf) sp_flg = 5'b00000;
    else if (b_zero) sp_flg = 5'b01000;
    else if (a_zero | b_inf) sp_res = {sab, {(W-1){1'b0}}};
    else sp = 1'b0;
  end
  assign ge = r >= {1'b0, mb};
  assign r_sub = ge ? r - {1'b0, mb} : r;
  assign g = q[1];
  assign st = q[0] | (|r);
`ifdef FPDIV_RNE_EN
  assign up = g & (st | q[2]);
`else
  assign up = 1'b0;
`endif
  assign sum = {1'b0, q[MAN_W+2:2]} + (MAN_W+2)'(up);
  assign e_r = e + EW'(sum[MAN_W+1]);
  assign frac = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign of = ~e_r[EW-1] & (e_r >= E_MAX);
  assign uf = e_r[EW-1] | (e_r == '0);
  assign rnd_res = of ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                   uf ? {sign, {(W-1){1'b0}}} : {sign, e_r[EXP_W-1:0], frac};
  assign rnd_flg = {2'b00, of, uf, g | st | of | uf};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? UNPACK : IDLE;
      UNPACK:  state_n = sp ? DONE : DIVIDE;
      DIVIDE:  state_n = (cnt == CW'(MAN_W + 2)) ? NORM : DIVIDE;
      NORM:    state_n = ROUND;
      ROUND:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      result <= '0;
      flags <= '0;
      done <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sign <= 1'b0;
      e <= '0;
      mb <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      res <= '0;
      flg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
        end
        UNPACK: begin
          sign <= sab;
          e <= e_u;
          mb <= {1'b1, fb};
          r <= {2'b01, fa};
          q <= '0;
          cnt <= '0;
          res <= sp_res;
          flg <= sp_flg;
        end
        DIVIDE: begin
          r <= r_sub << 1;
          q <= {q[MAN_W+1:0], ge};
          cnt <= cnt + CW'(1);
        end
        NORM: if (!q[MAN_W+2]) begin
          q <= q << 1;
          e <= e - EW'(1);
        end
        ROUND: begin
          res <= rnd_res;
          flg <= rnd_flg;
        end
        default: begin
          result <= res;
          flags <= flg;
          done <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_fp_divider_param.sv
// tb_fp_divider_param: directed vectors for the single- and half-precision divider builds.
module tb_fp_divider_param;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, h_start = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic [15:0] h_a = '0, h_b = '0, h_result;
  logic done, busy, h_done, h_busy;
  logic [4:0] flags, h_flags;
  int vecs = 0, miss = 0;
  int n;
  bit seen;
`ifdef FPDIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif
  fp_divider_param dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .flags(flags));
  fp_divider_param #(.EXP_W(5), .MAN_W(10)) hdut (.clk(clk), .rst_n(rst_n), .start(h_start),
    .a(h_a), .b(h_b), .result(h_result), .done(h_done), .busy(h_busy), .flags(h_flags));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [31:0] av, input logic [31:0] bv, input int lat,
                    input logic [31:0] er, input logic [4:0] ef, input string tag, input int poke = 0);
    int k;
    bit busy_ok;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_ok = busy;
    k = 0;
    while (!done && k < 60) begin
      if (poke != 0 && k == poke) begin
        start = 1'b1;
        a = 32'h3F800000;
        b = 32'h40400000;
      end
      if (poke != 0 && k == poke + 1) start = 1'b0;
      @(posedge clk);
      #1 k++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    chk({tag, " latency"}, 32'(k), 32'(lat));
    chk({tag, " busy"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, 32'(flags), 32'(ef));
  endtask
  initial begin
    #12;
    chk("reset result", result, 32'h0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    op(32'h40C00000, 32'h40000000, 30, 32'h40400000, 5'b00000, "6/2");
    @(posedge clk);
    #1 chk("done pulse width", 32'(done), 32'd0);
    op(32'h3F800000, 32'h40400000, 30, THIRD, 5'b00001, "1/3");
    op(32'hC0C00000, 32'h40000000, 30, 32'hC0400000, 5'b00000, "-6/2");
    op(32'h3F800000, 32'h00000000, 2, 32'h7F800000, 5'b01000, "1/0");
    op(32'h00000000, 32'h00000000, 2, 32'h7FC00000, 5'b10000, "0/0");
    op(32'hC0000000, 32'h7F800000, 2, 32'h80000000, 5'b00000, "-2/inf");
    op(32'h7FC00001, 32'h3F800000, 2, 32'h7FC00000, 5'b00000, "nan/1");
    op(32'h7F800000, 32'h7F800000, 2, 32'h7FC00000, 5'b10000, "inf/inf");
    op(32'h7F000000, 32'h3E800000, 30, 32'h7F800000, 5'b00101, "overflow");
    op(32'h00800000, 32'h47000000, 30, 32'h00000000, 5'b00011, "underflow");
    op(32'h40C00000, 32'h40000000, 30, 32'h40400000, 5'b00000, "ignore start", 5);
    op(32'h3F800000, 32'h40400000, 30, THIRD, 5'b00001, "pre-reset");
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort result", result, 32'h0);
    chk("abort flags", 32'(flags), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    chk("abort no done", 32'(seen), 32'd0);
    op(32'h40C00000, 32'h40000000, 30, 32'h40400000, 5'b00000, "after reset");
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("b2b first latency", 32'(n), 32'd30);
    chk("b2b first result", result, 32'h40400000);
    a = 32'h3F800000;
    b = 32'h40400000;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b accepted", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("b2b second latency", 32'(n), 32'd30);
    chk("b2b second result", result, THIRD);
    @(negedge clk);
    h_a = 16'h3C00;
    h_b = 16'h4000;
    h_start = 1'b1;
    @(posedge clk);
    #1 h_start = 1'b0;
    n = 0;
    while (!h_done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("half latency", 32'(n), 32'd17);
    chk("half result", 32'(h_result), 32'h3800);
    chk("half flags", 32'(h_flags), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
